bf16_logit_collector: RTL and testbench

//   Gathers a frame of serially streamed bfloat16 logits from the NPU output stream into a
//   10-entry parallel bank. It then presents that bank to the 10-input bf16 max-find stage.

---
 rtl/npu_bf16_pkg.sv | 36 +++
 rtl/bf16_greater.sv | 15 +
 rtl/bf16_logit_collector.sv | 155 +++++++++++++++
 tb/tb_bf16_logit_collector.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_bf16_pkg.sv
// Shared bfloat16 definitions for the NPU output path: widths, the -inf constant,
// the sign-magnitude ordering function and the collector FSM state type.
package npu_bf16_pkg;

    localparam int unsigned BF16_W = 16;
    localparam logic [BF16_W-1:0] BF16_NEG_INF = 16'hFF80;

    typedef enum logic [0:0] {
        FILL,
        HOLD
    } coll_state_e;

    // a > b under bf16 sign-magnitude ordering. +0 and -0 compare equal; NaN gets no
    // special treatment and falls out of the same bit rule.
    function automatic logic bf16_gt(input logic [BF16_W-1:0] a, input logic [BF16_W-1:0] b);
        logic a_zero;
        logic b_zero;
        logic gt;
        a_zero = (a[BF16_W-2:0] == '0);
        b_zero = (b[BF16_W-2:0] == '0);
        gt     = 1'b0;
        if (a_zero && b_zero) begin
            gt = 1'b0;
        end else if (!a[BF16_W-1] && b[BF16_W-1]) begin
            gt = 1'b1;
        end else if (a[BF16_W-1] && !b[BF16_W-1]) begin
            gt = 1'b0;
        end else if (!a[BF16_W-1]) begin
            gt = (a[BF16_W-2:0] > b[BF16_W-2:0]);
        end else begin
            gt = (a[BF16_W-2:0] < b[BF16_W-2:0]);
        end
        return gt;
    endfunction

endpackage

// File: rtl/bf16_greater.sv
// Combinational bf16 comparator: gt_o = (a_i > b_i) in sign-magnitude order.
module bf16_greater
    import npu_bf16_pkg::*;
(
    input  logic [BF16_W-1:0] a_i,
    input  logic [BF16_W-1:0] b_i,
    output logic              gt_o
);

    // Pure wrapper so the comparator shows up as its own instance in the hierarchy.
    always_comb begin
        gt_o = bf16_gt(a_i, b_i);
    end

endmodule

// File: rtl/bf16_logit_collector.sv
// Serial-to-parallel collector for a frame of bf16 logits feeding the 10-input max-find.
// Optional feature: define LOGIT_ARGMAX_EN to track a running argmax/max as beats arrive;
// without it out_argmax and out_max are tied to zero and no comparator is built.
module bf16_logit_collector
    import npu_bf16_pkg::*;
#(
    parameter int unsigned NUM_LOGITS = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LOGITS*DATA_W-1:0] out_logits,
    output logic                         out_err,
    output logic [IDX_W-1:0]             out_argmax,
    output logic [DATA_W-1:0]            out_max
);

    localparam logic [DATA_W-1:0] NegInf  = DATA_W'(BF16_NEG_INF);
    localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(NUM_LOGITS - 1);

    coll_state_e       state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] slot_q [NUM_LOGITS];
    logic [DATA_W-1:0] slot_d [NUM_LOGITS];

    logic accept;
    logic last_slot;
    logic frame_close;
    logic frame_release;

    assign in_ready      = (state_q == FILL);
    assign out_valid     = (state_q == HOLD);
    assign out_err       = err_q;
    assign accept        = in_valid && in_ready;
    assign last_slot     = (wr_idx_q == LastIdx);
    assign frame_close   = accept && (in_last || last_slot);
    assign frame_release = out_valid && out_ready;

    // FSM next state, write pointer and length-error flag.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        err_d    = err_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (frame_close) begin
                        state_d = HOLD;
                        // Error unless in_last coincides exactly with the final slot.
                        err_d   = in_last ^ last_slot;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = FILL;
                    wr_idx_d = '0;
                    err_d    = 1'b0;
                end
            end
        endcase
    end

    // Slot bank: decoded write of the accepted beat, wholesale clear to -inf on release.
    always_comb begin
        for (int k = 0; k < NUM_LOGITS; k++) begin
            slot_d[k] = slot_q[k];
            if (frame_release) begin
                slot_d[k] = NegInf;
            end else if (accept && (wr_idx_q == IDX_W'(k))) begin
                slot_d[k] = in_data;
            end
        end
    end

    // State, pointer, error and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < NUM_LOGITS; k++) begin
                slot_q[k] <= NegInf;
            end
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            err_q    <= err_d;
            for (int k = 0; k < NUM_LOGITS; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // Flatten the bank onto the output bus, slot k at [DATA_W*k +: DATA_W].
    always_comb begin
        out_logits = '0;
        for (int k = 0; k < NUM_LOGITS; k++) begin
            out_logits[DATA_W*k +: DATA_W] = slot_q[k];
        end
    end

`ifdef LOGIT_ARGMAX_EN
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    logic              beat_gt;

    bf16_greater u_beat_gt (
        .a_i  (in_data),
        .b_i  (run_max_q),
        .gt_o (beat_gt)
    );

    // Running max: first beat always loads; later beats only on strictly greater, so ties
    // keep the earlier index. Padding slots are never seen here.
    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (frame_release) begin
            run_max_d = NegInf;
            run_idx_d = '0;
        end else if (accept && (beat_gt || (wr_idx_q == '0))) begin
            run_max_d = in_data;
            run_idx_d = wr_idx_q;
        end
    end

    // Running max registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_max_q <= NegInf;
            run_idx_q <= '0;
        end else begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
        end
    end

    assign out_max    = run_max_q;
    assign out_argmax = run_idx_q;
`else
    assign out_max    = '0;
    assign out_argmax = '0;
`endif

endmodule

// File: tb/tb_bf16_logit_collector.sv
// Self-checking bench for bf16_logit_collector: directed frames plus randomized traffic,
// checked every cycle against a frame-level reference model (queue of accepted beats).
module tb_bf16_logit_collector;

    localparam int N = 10;
    localparam logic [15:0] NEG_INF = 16'hFF80;
    localparam logic [15:0] SPECIALS [6] = '{16'h0000, 16'h8000, 16'h3F80, 16'hBF80,
                                             16'h7F80, 16'hFF80};

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [159:0]  out_logits;
    logic          out_err;
    logic [3:0]    out_argmax;
    logic [15:0]   out_max;

    bf16_logit_collector dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_logits (out_logits),
        .out_err    (out_err),
        .out_argmax (out_argmax),
        .out_max    (out_max)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats of the current frame, whether the frame is closed, and
    // whether it closed on in_last.
    logic [15:0] cur [$];
    bit          held;
    bit          closed_last;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Map bf16 onto a signed integer that orders the same way (+0 and -0 both map to 0).
    function automatic int order_key(input logic [15:0] v);
        int mag;
        mag = int'({17'd0, v[14:0]});
        return v[15] ? -mag : mag;
    endfunction

    function automatic logic [159:0] exp_bank();
        logic [159:0] b;
        for (int k = 0; k < N; k++) begin
            b[16*k +: 16] = (k < cur.size()) ? cur[k] : NEG_INF;
        end
        return b;
    endfunction

    function automatic int exp_best();
        int best;
        best = 0;
        for (int i = 1; i < cur.size(); i++) begin
            if (order_key(cur[i]) > order_key(cur[best])) best = i;
        end
        return best;
    endfunction

    task automatic check_outputs();
        logic exp_err;
        exp_err = held && !((cur.size() == N) && closed_last);
        check_eq("in_ready", in_ready, !held);
        check_eq("out_valid", out_valid, held);
        check_eq("out_logits", out_logits, exp_bank());
        check_eq("out_err", out_err, exp_err);
`ifdef LOGIT_ARGMAX_EN
        check_eq("out_argmax", out_argmax, 4'(exp_best()));
        check_eq("out_max", out_max, (cur.size() == 0) ? NEG_INF : cur[exp_best()]);
`else
        check_eq("out_argmax", out_argmax, 4'd0);
        check_eq("out_max", out_max, 16'd0);
`endif
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model.
    task automatic step(input bit v, input logic [15:0] d, input bit l, input bit r);
        @(negedge clk);
        check_outputs();
        reset     = 1'b0;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        if (held) begin
            if (r) begin
                held = 1'b0;
                cur.delete();
            end
        end else if (v) begin
            cur.push_back(d);
            if (l || (cur.size() == N)) begin
                held        = 1'b1;
                closed_last = l;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        cur.delete();
        held        = 1'b0;
        closed_last = 1'b0;
    endtask

    task automatic release_frame();
        step(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    logic [15:0] d;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_logits", out_logits, {10{16'hFF80}});
        check_eq("rst_err", out_err, 1'b0);
`ifdef LOGIT_ARGMAX_EN
        check_eq("rst_max", out_max, 16'hFF80);
`else
        check_eq("rst_max", out_max, 16'h0000);
`endif

        // 1: one hot 1.0 in slot 3, in_last on beat 10.
        for (int i = 0; i < N; i++) step(1'b1, (i == 3) ? 16'h3F80 : 16'h0000, i == N - 1, 1'b0);
        #1;
        check_eq("t1_valid", out_valid, 1'b1);
        check_eq("t1_logits", out_logits, {{6{16'h0000}}, 16'h3F80, {3{16'h0000}}});
        check_eq("t1_err", out_err, 1'b0);
`ifdef LOGIT_ARGMAX_EN
        check_eq("t1_argmax", out_argmax, 4'd3);
        check_eq("t1_max", out_max, 16'h3F80);
`endif
        release_frame();

        // 2: early close after 4 beats.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h4000, i == 3, 1'b0);
        #1;
        check_eq("t2_logits", out_logits, {{6{16'hFF80}}, {4{16'h4000}}});
        check_eq("t2_err", out_err, 1'b1);
        check_eq("t2_argmax", out_argmax, 4'd0);
        release_frame();

        // 3: backpressure for 5 cycles, then release.
        for (int i = 0; i < N; i++) step(1'b1, 16'($urandom), i == N - 1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h1111, 1'b0, 1'b0);
        #1;
        check_eq("t3_held_valid", out_valid, 1'b1);
        check_eq("t3_held_ready", in_ready, 1'b0);
        release_frame();
        #1;
        check_eq("t3_in_ready", in_ready, 1'b1);
        check_eq("t3_cleared", out_logits, {10{16'hFF80}});

        // 4: reset after a partial frame, then a clean frame.
        for (int i = 0; i < 6; i++) step(1'b1, 16'h5555, 1'b0, 1'b0);
        do_reset();
        #1;
        check_eq("t4_valid", out_valid, 1'b0);
        check_eq("t4_logits", out_logits, {10{16'hFF80}});
        for (int i = 0; i < N; i++) step(1'b1, 16'(16'h0100 + i), i == N - 1, 1'b0);
        #1;
        check_eq("t4_err", out_err, 1'b0);
        check_eq("t4_slot0", out_logits[15:0], 16'h0100);
        release_frame();

        // 5: all -1.0 except -2.0 at beat 7; tie keeps index 0.
        for (int i = 0; i < N; i++) step(1'b1, (i == 6) ? 16'hC000 : 16'hBF80, i == N - 1, 1'b0);
        #1;
`ifdef LOGIT_ARGMAX_EN
        check_eq("t5_argmax", out_argmax, 4'd0);
        check_eq("t5_max", out_max, 16'hBF80);
`endif
        check_eq("t5_slot6", out_logits[111:96], 16'hC000);
        release_frame();

        // 6: no in_last; frame closes at beat 10 with error; beat 11 goes to slot 0.
        for (int i = 0; i < N; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        #1;
        check_eq("t6_valid", out_valid, 1'b1);
        check_eq("t6_err", out_err, 1'b1);
        release_frame();
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        #1;
        check_eq("t6_next_slot0", out_logits[15:0], 16'h1234);
        release_frame();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(1) == 0) d = 16'($urandom);
                else d = SPECIALS[$urandom_range(5)];
                step($urandom_range(9) < 7, d, $urandom_range(7) == 0, $urandom_range(1) == 1);
            end
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
